// File: rtl/i2c_oled_master.sv
// Bit-level I2C write master for the SSD1306 power-up sequence: START, address, control,
// CMD_COUNT command bytes, STOP. Define I2C_NACK_RETRY_EN to retry up to 3 times on NACK.
module i2c_oled_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CMD_COUNT = 18
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       read_write,
    input  logic [7:0] control_frame,
    input  logic [7:0] reg_addr,
    input  logic       sda_in,
    output logic [3:0] state,
    output logic [4:0] command_queue,
    output logic [7:0] control_queue,
    output logic [7:0] data_queue,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StStart  = 4'd1,
        StRecog  = 4'd2,
        StWrCtrl = 4'd3,
        StWrCmd  = 4'd4,
        StAck    = 4'd7,
        StStop   = 4'd8
    } st_e;

    localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
    localparam logic [4:0]     CmdLast = 5'(CMD_COUNT - 1);

    st_e            st_q, last_q;
    logic [DivW-1:0] div_q;
    logic [1:0]     qtr_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic [4:0]     cmd_q;
    logic           nack_q, done_q, scl_q, sda_oe_q;
    logic           scl_d, sda_d;
    logic           tick;
`ifdef I2C_NACK_RETRY_EN
    logic [1:0]     retry_q;
    logic           restart_q;
`endif

    assign tick = (div_q == DivMax);

    // START/STOP phases each last one full bit cell (bit_q[1:0] is the phase).
    // SDA is only allowed to move once SCL is already low, one cycle after the fall.
    always_comb begin
        scl_d = 1'b1;
        sda_d = sda_oe_q;
        case (st_q)
            StIdle: begin
                scl_d = 1'b1;
                sda_d = 1'b0;
            end
            StStart: begin
                scl_d = 1'b1;
                sda_d = bit_q[1];
            end
            StRecog, StWrCtrl, StWrCmd: begin
                scl_d = qtr_q[1];
                if (!qtr_q[1] && !scl_q) sda_d = ~shift_q[7];
            end
            StAck: begin
                scl_d = qtr_q[1];
                if (!qtr_q[1] && !scl_q) sda_d = 1'b0;
            end
            StStop: begin
                if (bit_q[1:0] == 2'd0) begin
                    scl_d = 1'b0;
                    if (!scl_q) sda_d = 1'b1;
                end else begin
                    scl_d = 1'b1;
                    sda_d = (bit_q[1:0] != 2'd3);
                end
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q     <= StIdle;
            last_q   <= StIdle;
            div_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            cmd_q    <= 5'd0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            retry_q   <= 2'd0;
            restart_q <= 1'b0;
`endif
        end else begin
            scl_q    <= scl_d;
            sda_oe_q <= sda_d;
            done_q   <= 1'b0;
            if (st_q == StIdle) begin
                div_q <= '0;
                qtr_q <= 2'd0;
                bit_q <= 3'd0;
                if (start) begin
                    st_q   <= StStart;
                    cmd_q  <= 5'd0;
                    nack_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
                    retry_q   <= 2'd0;
                    restart_q <= 1'b0;
`endif
                end
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    qtr_q <= qtr_q + 2'd1;
                    case (st_q)
                        StStart: begin
                            if (qtr_q == 2'd3) begin
                                bit_q <= bit_q + 3'd1;
                                if (bit_q[1:0] == 2'd3) begin
                                    bit_q   <= 3'd0;
                                    shift_q <= {slave_addr, read_write};
                                    st_q    <= StRecog;
                                end
                            end
                        end
                        StRecog, StWrCtrl, StWrCmd: begin
                            // Late load gives the lookup stage time to follow command_queue.
                            if (st_q == StWrCmd && bit_q == 3'd0 && qtr_q == 2'd0)
                                shift_q <= reg_addr;
                            if (qtr_q == 2'd3) begin
                                shift_q <= {shift_q[6:0], 1'b1};
                                bit_q   <= bit_q + 3'd1;
                                if (bit_q == 3'd7) begin
                                    last_q <= st_q;
                                    st_q   <= StAck;
                                end
                            end
                        end
                        StAck: begin
                            if (qtr_q == 2'd3) begin
                                if (sda_in) begin
`ifdef I2C_NACK_RETRY_EN
                                    if (retry_q != 2'd3) begin
                                        retry_q   <= retry_q + 2'd1;
                                        restart_q <= 1'b1;
                                    end else begin
                                        nack_q <= 1'b1;
                                    end
`else
                                    nack_q <= 1'b1;
`endif
                                    st_q <= StStop;
                                end else begin
                                    case (last_q)
                                        StRecog: begin
                                            shift_q <= control_frame;
                                            st_q    <= StWrCtrl;
                                        end
                                        StWrCtrl: begin
                                            cmd_q <= 5'd0;
                                            st_q  <= StWrCmd;
                                        end
                                        default: begin
                                            if (cmd_q < CmdLast) begin
                                                cmd_q <= cmd_q + 5'd1;
                                                st_q  <= StWrCmd;
                                            end else begin
                                                st_q <= StStop;
                                            end
                                        end
                                    endcase
                                end
                            end
                        end
                        StStop: begin
                            if (qtr_q == 2'd3) begin
                                bit_q <= bit_q + 3'd1;
                                if (bit_q[1:0] == 2'd3) begin
                                    bit_q <= 3'd0;
`ifdef I2C_NACK_RETRY_EN
                                    if (restart_q) begin
                                        restart_q <= 1'b0;
                                        cmd_q     <= 5'd0;
                                        st_q      <= StStart;
                                    end else begin
`else
                                    begin
`endif
                                        st_q   <= StIdle;
                                        done_q <= ~nack_q;
                                    end
                                end
                            end
                        end
                        default: st_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign state         = st_q;
    assign command_queue = cmd_q;
    assign control_queue = 8'd0;
    assign data_queue    = 8'd0;
    assign scl           = scl_q;
    assign sda_oe        = sda_oe_q;
    assign busy          = (st_q != StIdle);
    assign done          = done_q;
    assign nack_err      = nack_q;

endmodule
